// File: rtl/vga_fb_reader.sv
// Frame-buffer read master: streams FRAME_WORDS words from a BRAM port, prefetches
// them into a small FIFO and hands them out as pixels, LSB-first, on a valid/ready
// interface.
// Latency: a frame_start_i pulse sampled at edge 0 drives ena_o high in the cycle
//   after edge 0. The BRAM samples that read at edge 1, and the word is pushed at
//   edge 2. pixel_valid_o is high after edge 2.
// Backpressure: pixel_ready_i low holds the current pixel. Reads stop issuing once
//   the buffered words plus the in-flight read fill the FIFO.
// Optional macro: VGA_FB_UNDERRUN_CNT_EN enables the saturating 16-bit
//   underrun_cnt_o. When the macro is undefined, underrun_cnt_o is tied to 0.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   en_i, frame_start_i     : fetch enable, restart-at-word-0 pulse
//   addra_o/ena_o/wea_o/dina_o/douta_i : BRAM port A (read-only use)
//   pixel_o/pixel_valid_o/pixel_ready_i: pixel stream
//   underrun_o, underrun_cnt_o         : starvation pulse and counter
module vga_fb_reader #(
    parameter int RAM_WIDTH   = 18,
    parameter int ADDR_WIDTH  = 10,
    parameter int PIXEL_WIDTH = 3,
    parameter int FRAME_WORDS = 1024,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic                   frame_start_i,
    output logic [ADDR_WIDTH-1:0]  addra_o,
    output logic                   ena_o,
    output logic                   wea_o,
    output logic [RAM_WIDTH-1:0]   dina_o,
    input  logic [RAM_WIDTH-1:0]   douta_i,
    output logic [PIXEL_WIDTH-1:0] pixel_o,
    output logic                   pixel_valid_o,
    input  logic                   pixel_ready_i,
    output logic                   underrun_o,
    output logic [15:0]            underrun_cnt_o
);

    localparam int PPW   = RAM_WIDTH / PIXEL_WIDTH;
    localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(PPW - 1);

    // Elaboration-time parameter sanity checks.
    if (RAM_WIDTH % PIXEL_WIDTH != 0) begin : g_bad_pixel_width
        $error("RAM_WIDTH must be an integer multiple of PIXEL_WIDTH");
    end
    if (FRAME_WORDS > (2 ** ADDR_WIDTH) || FRAME_WORDS < 1) begin : g_bad_frame_words
        $error("FRAME_WORDS must be in 1..2**ADDR_WIDTH");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   inflight_q;

    logic [RAM_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [IDX_W-1:0]       idx_q, idx_d;

    logic                   issue;
    logic                   push;
    logic                   pop;
    logic                   pix_xfer;
    logic                   fifo_vld;
    logic [RAM_WIDTH-1:0]   head_word;

    // The in-flight read already owns a FIFO slot. Counting it here keeps the
    // FIFO from overflowing when its data lands. Reads are suppressed during
    // frame_start_i so that nothing from the old frame is in flight afterwards.
    assign issue = (state_q == S_FETCH) && en_i && !frame_start_i &&
                   ((count_q + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH));

    assign push     = inflight_q && !frame_start_i;
    assign fifo_vld = (count_q != '0);
    assign pix_xfer = fifo_vld && pixel_ready_i;
    assign pop      = pix_xfer && (idx_q == LAST_IDX) && !frame_start_i;

    assign addra_o = addr_q;
    assign ena_o   = issue;
    assign wea_o   = 1'b0;
    assign dina_o  = '0;

    assign head_word     = mem_q[rd_ptr_q];
    assign pixel_valid_o = fifo_vld;
    // Gated so the output reads 0 while the FIFO holds no valid data.
    assign pixel_o       = fifo_vld ? head_word[idx_q*PIXEL_WIDTH +: PIXEL_WIDTH] : '0;
    assign underrun_o    = pixel_ready_i && !fifo_vld && (state_q == S_FETCH);

    // Fetch sequencer: state, read address and in-flight flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            inflight_q <= 1'b0;
        end else if (frame_start_i) begin
            state_q    <= S_FETCH;
            addr_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                if (addr_q == LAST_ADDR) begin
                    addr_q  <= '0;
                    state_q <= S_DONE;
                end else begin
                    addr_q <= addr_q + 1'b1;
                end
            end
        end
    end

    // Prefetch FIFO and pixel index next-state logic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        idx_d    = idx_q;
        if (frame_start_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            idx_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (pix_xfer) begin
                idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
        end
    end

    // Storage carries no reset: every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= douta_i;
        end
    end

`ifdef VGA_FB_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (frame_start_i) begin
            ucnt_d = '0;
        end else if (underrun_o && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_cnt_o = ucnt_q;
`else
    assign underrun_cnt_o = '0;
`endif

endmodule
